// File: rtl/fifo_wr_ctrl_mc_if.sv
// Request/status bundle between channel producers/consumers and the multi-channel
// FIFO pointer controller; per-channel fields are packed channel 0 in the LSBs.
interface fifo_wr_ctrl_mc_if #(
   parameter int NUM_CH = 4,
   parameter int PTR    = 2
);
   logic [NUM_CH-1:0]         wr_req;
   logic [NUM_CH-1:0]         rd_req;
   logic [PTR:0]              af_thresh;
   logic [PTR:0]              ae_thresh;
   logic [NUM_CH-1:0]         err_clr;
   logic [NUM_CH-1:0]         push;
   logic [NUM_CH-1:0]         pop;
   logic [NUM_CH*PTR-1:0]     wr_ptr;
   logic [NUM_CH*PTR-1:0]     rd_ptr;
   logic [NUM_CH*(PTR+1)-1:0] count;
   logic [NUM_CH-1:0]         full;
   logic [NUM_CH-1:0]         empty;
   logic [NUM_CH-1:0]         almost_full;
   logic [NUM_CH-1:0]         almost_empty;
   logic [NUM_CH-1:0]         overflow_err;
   logic [NUM_CH-1:0]         underflow_err;

   modport master (
      output wr_req, rd_req, af_thresh, ae_thresh, err_clr,
      input  push, pop, wr_ptr, rd_ptr, count, full, empty,
             almost_full, almost_empty, overflow_err, underflow_err
   );

   modport slave (
      input  wr_req, rd_req, af_thresh, ae_thresh, err_clr,
      output push, pop, wr_ptr, rd_ptr, count, full, empty,
             almost_full, almost_empty, overflow_err, underflow_err
   );
endinterface

// File: rtl/fifo_wr_ctrl_mc.sv
// NUM_CH independent circular-buffer pointer/occupancy controllers sharing one
// dual-port memory; DEPTH need not be a power of two.
module fifo_wr_ctrl_mc #(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 4,
   parameter int PTR    = 2
) (
   input logic              clk,
   input logic              reset,
   fifo_wr_ctrl_mc_if.slave bus
);
   localparam logic [PTR:0]   DEPTH_C = (PTR+1)'(DEPTH);
   localparam logic [PTR-1:0] LAST_C  = PTR'(DEPTH-1);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PTR-1:0] wr_ptr_q, wr_ptr_d;
      logic [PTR-1:0] rd_ptr_q, rd_ptr_d;
      logic [PTR:0]   count_q, count_d;
      logic           ovf_q, ovf_d;
      logic           udf_q, udf_d;
      logic           push_c, pop_c, full_c, empty_c;

      always_comb begin
         full_c  = (count_q == DEPTH_C);
         empty_c = (count_q == '0);
         // pop never looks at push, so the full-bypass term below cannot loop
         pop_c   = bus.rd_req[gi] & ~empty_c & ~reset;
         push_c  = bus.wr_req[gi] & (~full_c | pop_c) & ~reset;

         wr_ptr_d = wr_ptr_q;
         if (push_c) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
         end
         rd_ptr_d = rd_ptr_q;
         if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
         end

         count_d = count_q;
         if (push_c && !pop_c) begin
            count_d = count_q + 1'b1;
         end else if (pop_c && !push_c) begin
            count_d = count_q - 1'b1;
         end

         // a fresh error in the same cycle as a clear must survive
         ovf_d = (bus.wr_req[gi] & ~push_c & ~reset) | (ovf_q & ~bus.err_clr[gi]);
         udf_d = (bus.rd_req[gi] & ~pop_c & ~reset) | (udf_q & ~bus.err_clr[gi]);
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
         end
      end

      assign bus.push[gi]                   = push_c;
      assign bus.pop[gi]                    = pop_c;
      assign bus.wr_ptr[gi*PTR +: PTR]      = wr_ptr_q;
      assign bus.rd_ptr[gi*PTR +: PTR]      = rd_ptr_q;
      assign bus.count[gi*(PTR+1) +: PTR+1] = count_q;
      assign bus.full[gi]                   = full_c;
      assign bus.empty[gi]                  = empty_c;
      assign bus.almost_full[gi]  = (bus.af_thresh != '0) && (count_q >= bus.af_thresh);
      assign bus.almost_empty[gi] = (count_q <= bus.ae_thresh);
      assign bus.overflow_err[gi]           = ovf_q;
      assign bus.underflow_err[gi]          = udf_q;
   end
endmodule
